// File: rtl/fpnew_pkg.sv
// Shared FPU types: IEEE status flags and the result-buffer entry layout.
package fpnew_pkg;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  localparam int unsigned MAX_RESULT_BUF_DEPTH = 16;

  // Result is stored at the widest supported format; only the low Width bits are meaningful.
  typedef struct packed {
    logic [63:0] result;
    status_t     status;
    logic        ext_bit;
  } result_entry_t;

endpackage

// File: rtl/fpnew_result_buffer.sv
// FIFO output stage for an FPU opgroup, with sticky fflags and busy reporting.
// Optional zero-latency bypass when empty: define FPNEW_RESULT_BUFFER_BYPASS_EN.
module fpnew_result_buffer
  import fpnew_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Depth   = 2,
  parameter type         TagType = logic
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [Width-1:0]   result_i,
  input  status_t            status_i,
  input  logic               extension_bit_i,
  input  TagType             tag_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [Width-1:0]   result_o,
  output status_t            status_o,
  output logic               extension_bit_o,
  output TagType             tag_o,
  input  logic               clr_flags_i,
  output status_t            flags_o,
  output logic               busy_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  result_entry_t   mem_q [Depth];
  TagType          tag_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  status_t         flags_q;

  logic            empty, push, pop, write_en, read_en;
  result_entry_t   wr_entry, rd_entry;
  logic [63:0]     unused_rd_result;

  assign unused_rd_result = rd_entry.result;

  // Handshake, head selection and the push/pop qualifiers that actually touch storage.
  always_comb begin
    empty           = (count_q == '0);
    rd_entry        = mem_q[rd_ptr_q];
    wr_entry        = '0;
    wr_entry.result[Width-1:0] = result_i;
    wr_entry.status  = status_i;
    wr_entry.ext_bit = extension_bit_i;
    in_ready_o      = (count_q != FullCnt) & ~flush_i;
    push            = in_valid_i & in_ready_o;
    busy_o          = ~empty;
`ifdef FPNEW_RESULT_BUFFER_BYPASS_EN
    out_valid_o     = ~flush_i & (~empty | in_valid_i);
    result_o        = empty ? result_i        : rd_entry.result[Width-1:0];
    status_o        = empty ? status_i        : rd_entry.status;
    extension_bit_o = empty ? extension_bit_i : rd_entry.ext_bit;
    tag_o           = empty ? tag_i           : tag_q[rd_ptr_q];
    pop             = out_valid_o & out_ready_i;
    write_en        = push & ~(empty & out_ready_i);
    read_en         = pop & ~empty;
`else
    out_valid_o     = ~empty & ~flush_i;
    result_o        = rd_entry.result[Width-1:0];
    status_o        = rd_entry.status;
    extension_bit_o = rd_entry.ext_bit;
    tag_o           = tag_q[rd_ptr_q];
    pop             = out_valid_o & out_ready_i;
    write_en        = push;
    read_en         = pop;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= wr_entry;
      tag_q[wr_ptr_q] <= tag_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (write_en) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (read_en)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (write_en && !read_en)      count_q <= count_q + 1'b1;
      else if (read_en && !write_en) count_q <= count_q - 1'b1;
    end
  end

  // A status popped in the same cycle as a clear still lands in the flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) flags_q <= '0;
    else       flags_q <= status_t'((clr_flags_i ? 5'b0 : flags_q) | (pop ? status_o : 5'b0));
  end

  assign flags_o = flags_q;

endmodule

// File: tb/tb_fpnew_result_buffer.sv
// Directed self-checking bench for fpnew_result_buffer (Depth=2 and Depth=3 instances).
module tb_fpnew_result_buffer;
  import fpnew_pkg::*;

  typedef logic [3:0] tag_t;

  logic    clk = 1'b0;
  logic    rst;
  logic    in_valid, flush, out_ready, clr_flags, ext;
  logic [31:0] result;
  status_t status;
  tag_t    tag;

  logic    d2_in_ready, d2_out_valid, d2_ext, d2_busy;
  logic [31:0] d2_result;
  status_t d2_status, d2_flags;
  tag_t    d2_tag;

  logic    d3_in_ready, d3_out_valid, d3_ext, d3_busy;
  logic [31:0] d3_result;
  status_t d3_status, d3_flags;
  tag_t    d3_tag;

  int checks_total  = 0;
  int checks_passed = 0;
  bit bypass_en;

  always #5 clk = ~clk;

  fpnew_result_buffer #(.Width(32), .Depth(2), .TagType(tag_t)) dut2 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(d2_in_ready),
    .result_i(result), .status_i(status), .extension_bit_i(ext), .tag_i(tag),
    .flush_i(flush), .out_valid_o(d2_out_valid), .out_ready_i(out_ready),
    .result_o(d2_result), .status_o(d2_status), .extension_bit_o(d2_ext), .tag_o(d2_tag),
    .clr_flags_i(clr_flags), .flags_o(d2_flags), .busy_o(d2_busy)
  );

  fpnew_result_buffer #(.Width(32), .Depth(3), .TagType(tag_t)) dut3 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(d3_in_ready),
    .result_i(result), .status_i(status), .extension_bit_i(ext), .tag_i(tag),
    .flush_i(flush), .out_valid_o(d3_out_valid), .out_ready_i(out_ready),
    .result_o(d3_result), .status_o(d3_status), .extension_bit_o(d3_ext), .tag_o(d3_tag),
    .clr_flags_i(clr_flags), .flags_o(d3_flags), .busy_o(d3_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, observed, expected);
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle before checks.
  task automatic applyStimulus(input logic iv, input logic [31:0] res, input logic [4:0] st,
                               input tag_t tg, input logic ordy, input logic fl, input logic clr);
    in_valid  = iv;
    result    = res;
    status    = status_t'(st);
    tag       = tg;
    ext       = tg[0];
    out_ready = ordy;
    flush     = fl;
    clr_flags = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
`ifdef FPNEW_RESULT_BUFFER_BYPASS_EN
    bypass_en = 1'b1;
`else
    bypass_en = 1'b0;
`endif
    doReset();

    checkOutput("rst_out_valid", {31'b0, d2_out_valid}, 32'd0);
    checkOutput("rst_busy",      {31'b0, d2_busy},      32'd0);
    checkOutput("rst_flags",     {27'b0, d2_flags},     32'd0);
    checkOutput("rst_in_ready",  {31'b0, d2_in_ready},  32'd1);

    // Fill the Depth=2 buffer with the consumer stalled, then drain in order.
    applyStimulus(1'b1, 32'h11, 5'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready0", {31'b0, d2_in_ready}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h22, 5'b0, 4'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready1", {31'b0, d2_in_ready}, 32'd1);
    checkOutput("fill_head",   {28'b0, d2_tag},      32'd1);
    tick();
    applyStimulus(1'b1, 32'h33, 5'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("full_ready",  {31'b0, d2_in_ready}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_valid0", {31'b0, d2_out_valid}, 32'd1);
    checkOutput("drain_tag0",   {28'b0, d2_tag},       32'd1);
    checkOutput("drain_res0",   d2_result,             32'h11);
    tick();
    checkOutput("drain_ready",  {31'b0, d2_in_ready},  32'd1);
    checkOutput("drain_tag1",   {28'b0, d2_tag},       32'd2);
    tick();
    checkOutput("drained_valid", {31'b0, d2_out_valid}, 32'd0);
    checkOutput("drained_busy",  {31'b0, d2_busy},      32'd0);

    // Streaming on Depth=3: one result per cycle, pointers wrap several times.
    doReset();
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 32'(k), 5'b0, tag_t'(k), 1'b1, 1'b0, 1'b0);
      if (k >= 2) begin
        checkOutput("stream_valid", {31'b0, d3_out_valid}, 32'd1);
        checkOutput("stream_tag",   {28'b0, d3_tag},  bypass_en ? 32'(k) : 32'(k - 1));
        checkOutput("stream_busy",  {31'b0, d3_busy}, bypass_en ? 32'd0 : 32'd1);
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_tail_valid", {31'b0, d3_out_valid}, bypass_en ? 32'd0 : 32'd1);
    if (!bypass_en) checkOutput("stream_tail_tag", {28'b0, d3_tag}, 32'd10);
    tick();
    checkOutput("stream_end_valid", {31'b0, d3_out_valid}, 32'd0);

    // Sticky flags accumulate on pop; clear coincident with a pop keeps the popped status.
    doReset();
    applyStimulus(1'b1, 32'h1, 5'b00001, 4'd1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h2, 5'b10000, 4'd2, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("flags_before_pop", {27'b0, d2_flags},  32'd0);
    checkOutput("head_status0",     {27'b0, d2_status}, 32'h01);
    tick();
    checkOutput("flags_pop0",       {27'b0, d2_flags},  32'h01);
    checkOutput("head_status1",     {27'b0, d2_status}, 32'h10);
    tick();
    checkOutput("flags_pop1",       {27'b0, d2_flags},  32'h11);
    applyStimulus(1'b1, 32'h3, 5'b00100, 4'd3, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("flags_clr_pop",    {27'b0, d2_flags},  32'h04);

    // Flush with two held entries masks push and pop; flags stay put.
    applyStimulus(1'b1, 32'h7, 5'b11111, 4'd7, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h8, 5'b11111, 4'd8, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h9, 5'b11111, 4'd9, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_in_ready",  {31'b0, d2_in_ready},  32'd0);
    checkOutput("flush_out_valid", {31'b0, d2_out_valid}, 32'd0);
    checkOutput("flush_busy",      {31'b0, d2_busy},      32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush_busy",  {31'b0, d2_busy},     32'd0);
    checkOutput("post_flush_valid", {31'b0, d2_out_valid}, 32'd0);
    checkOutput("post_flush_flags", {27'b0, d2_flags},    32'h04);
    checkOutput("post_flush_ready", {31'b0, d2_in_ready}, 32'd1);
    applyStimulus(1'b1, 32'h5, 5'b0, 4'd5, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("refill_tag",   {28'b0, d2_tag},       32'd5);
    checkOutput("refill_valid", {31'b0, d2_out_valid}, 32'd1);

    // Asynchronous reset drops held entries without waiting for a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'b0, d2_out_valid}, 32'd0);
    checkOutput("async_rst_busy",  {31'b0, d2_busy},      32'd0);
    tick();
    rst = 1'b0;

    // Empty buffer with a ready consumer: bypass build forwards in the same cycle.
    applyStimulus(1'b1, 32'h3F800000, 5'b0, 4'd6, 1'b1, 1'b0, 1'b0);
    checkOutput("bypass_valid", {31'b0, d2_out_valid}, bypass_en ? 32'd1 : 32'd0);
    if (bypass_en) checkOutput("bypass_result", d2_result, 32'h3F800000);
    tick();
    applyStimulus(1'b0, 32'h0, 5'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("latency_busy",  {31'b0, d2_busy},      bypass_en ? 32'd0 : 32'd1);
    checkOutput("latency_valid", {31'b0, d2_out_valid}, bypass_en ? 32'd0 : 32'd1);
    if (!bypass_en) checkOutput("latency_result", d2_result, 32'h3F800000);
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/fpnew_result_buffer.md
Name: fpnew_result_buffer

Overview:
- Output stage directly downstream of an FPU operation-group block.
- Consumes that block's result, status, extension bit and tag over a valid/ready handshake, and holds them in a small FIFO. This decouples opgroup arbitration from the core's writeback stall.
- Accumulates sticky IEEE exception flags (fflags) for every result popped to the core.
- Reports busy while any result is held.

Parameters:
- Width, 32, result width in bits.
- Depth, 2, number of FIFO entries; legal range 1..16; need not be a power of two.
- TagType, logic, type of the tag carried alongside each result.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; one clock; asynchronous, active-high.
- in_valid_i  input  1  upstream result valid.
- in_ready_o  output  1  buffer can accept a result.
- result_i  input  Width  upstream result.
- status_i  input  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}.
- extension_bit_i  input  1  upstream extension bit.
- tag_i  input  TagType  upstream tag.
- flush_i  input  1  synchronous flush of all held results.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  core accepts the head entry.
- result_o  output  Width  head result.
- status_o  output  5  head status.
- extension_bit_o  output  1  head extension bit.
- tag_o  output  TagType  head tag.
- clr_flags_i  input  1  clear the sticky flags.
- flags_o  output  5  sticky OR of status over all popped entries.
- busy_o  output  1  at least one entry held.

Behaviour:
- Storage: Depth entries of {result, status, ext_bit, tag}.
- Pointers: read and write pointers of $clog2(Depth) bits (minimum 1 bit). A pointer wraps to 0 after reaching Depth-1.
- Count: $clog2(Depth+1) bits.
- Reset (asynchronous assertion, synchronous release):
  - pointers, count and flags are 0;
  - out_valid_o=0, busy_o=0, flags_o=0, in_ready_o=1;
  - storage contents are not reset; data outputs are don't-care while out_valid_o=0.
- Handshake signals:
  - in_ready_o = (count != Depth) & !flush_i. It does not depend on out_ready_i, so there is no combinational ready path.
  - push = in_valid_i & in_ready_o.
  - out_valid_o = (count != 0) & !flush_i.
  - pop = out_valid_o & out_ready_i.
- Latency: a pushed entry appears on out_valid_o the next cycle. Throughput is 1 entry/cycle when Depth>=2.
- Counting:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
  - Full (count==Depth): push is blocked; pop is still allowed.
  - Empty: pop is impossible.
- Order: strict FIFO; tags emerge in push order.
- Flush: pointers and count go to 0 next cycle and all entries are discarded. flush_i masks push and pop in the same cycle. flags_o is unaffected by flush.
- Sticky flags, next value:
  - base = clr_flags_i ? 0 : flags;
  - flags_next = base | (pop ? status_o : 0).
  - If clear and pop occur together, the popped status survives the clear.
- busy_o = (count != 0). busy_o stays high during the flush cycle and goes low the cycle after.
- Data outputs are driven from storage at the read pointer (combinational read).
- Reset mid-operation: all entries are lost immediately; out_valid_o deasserts asynchronously.

Optional Feature:
- Macro: FPNEW_RESULT_BUFFER_BYPASS_EN.
- Defined, when count==0 and flush_i=0:
  - out_valid_o = in_valid_i, and data outputs mux straight from the inputs.
  - If out_ready_i=1, the entry is consumed with zero latency and is not written. Count and pointers are unchanged, and flags accumulate status_i.
  - If out_ready_i=0, the entry is written normally.
  - in_ready_o is unchanged (1 when not full).
- Undefined: fixed 1-cycle latency; no input-to-output combinational path.

Decomposition:
- fpnew_pkg supplies status_t.
- Add to fpnew_pkg:
  - localparam MAX_RESULT_BUF_DEPTH = 16;
  - a packed struct result_entry_t {result, status, ext_bit}, where result has a fixed 64-bit maximum width and only Width bits are used.
- The tag is stored in a separate TagType array.
- The block is a single module; no sub-module.

Test Plan:
- Reset with no input → out_valid_o=0, busy_o=0, flags_o=5'b0, in_ready_o=1.
- Depth=2, out_ready_i=0:
  - push tags 1, 2 → in_ready_o=0 after the second push; a third push of tag 3 is not accepted.
  - then out_ready_i=1 → tags pop 1, 2 in order, and in_ready_o rises after the first pop.
- Back-to-back push+pop for 10 cycles with out_ready_i=1 → one result per cycle, count stays constant, pointers wrap correctly for Depth=3.
- Pop statuses 5'b00001 then 5'b10000 → flags_o=5'b10001. Then clr_flags_i together with a pop of status 5'b00100 → flags_o=5'b00100.
- Two entries held, flush_i pulsed with in_valid_i=1 and out_ready_i=1 → nothing pushed or popped; next cycle count=0, busy_o=0, flags_o unchanged.
- With FPNEW_RESULT_BUFFER_BYPASS_EN defined, empty buffer, in_valid_i=1, out_ready_i=1, result 32'h3F800000 → out_valid_o=1 in the same cycle with result_o=32'h3F800000 and busy_o stays 0. Without the macro, the result appears one cycle later.
